device_input_ctrl: RTL

- Input-side peripheral for the board: the read direction of the board I/O path, complementing the LED/7-segment output side.
- Synchronises and debounces the 24 switches and 5 buttons, detects button presses, and latches them as sticky events.
- Exposes switches, buttons, events and an interrupt mask to the CPU through the same addr/wen/wdata/rdata word bus the Bridge decodes.
- Sits between the board pins and the Bridge; the Bridge forwards its decoded window here.

---
 rtl/dev_input_pkg.sv | 20 ++
 rtl/debounce_bit.sv | 46 ++++
 rtl/device_input_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/dev_input_pkg.sv
// Shared constants for the board input peripheral: channel widths, register
// byte offsets inside the 16-byte window, and the default debounce period.
package dev_input_pkg;

  localparam int SW_W  = 24;
  localparam int BTN_W = 5;
  localparam int IN_W  = SW_W + BTN_W;

  localparam int DEFAULT_SAMPLE_PERIOD = 250000;

  localparam logic [3:0] OFF_SW   = 4'h0;
  localparam logic [3:0] OFF_BTN  = 4'h4;
  localparam logic [3:0] OFF_EVT  = 4'h8;
  localparam logic [3:0] OFF_MASK = 4'hC;

  function automatic logic [31:0] zext_btn(input logic [BTN_W-1:0] v);
    return {{(32-BTN_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, tick-sampled history, and a stable
// level that only moves once the whole history agrees.
module debounce_bit #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  logic [1:0]                sync_q, sync_d;
  logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
  logic                      dout_q, dout_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    hist_d = hist_q;
    dout_d = dout_q;
    if (tick) begin
      hist_d = {hist_q[STABLE_SAMPLES-2:0], sync_q[1]};
      // Judge on the history including the sample taken this tick.
      if (&hist_d) begin
        dout_d = 1'b1;
      end else if (~|hist_d) begin
        dout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/device_input_ctrl.sv
// Read-side board I/O peripheral: debounced switches and buttons, sticky
// button-press events with W1C clear, interrupt mask, and a word bus.
module device_input_ctrl
  import dev_input_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_F100,
  parameter int          SAMPLE_PERIOD  = DEFAULT_SAMPLE_PERIOD,
  parameter int          STABLE_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] device_sw,
  input  logic [4:0]  device_button,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  logic [IN_W-1:0]  raw_in;
  logic [IN_W-1:0]  stable;
  logic [SW_W-1:0]  stable_sw;
  logic [BTN_W-1:0] stable_btn;

  logic [BTN_W-1:0] btn_prev_q, btn_prev_d;
  logic [BTN_W-1:0] evt_q, evt_d;
  logic [BTN_W-1:0] mask_q, mask_d;
  logic [BTN_W-1:0] btn_rise;
  logic [BTN_W-1:0] evt_clr;

  logic       hit;
  logic [3:0] sel_off;
  logic       wr_evt;
  logic       wr_mask;
  logic       unused_bus_bits;

  // Shared sample tick for all debouncers.
  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  assign raw_in = {device_button, device_sw};

  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_db
      debounce_bit #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .din  (raw_in[gi]),
        .dout (stable[gi])
      );
    end
  endgenerate

  assign stable_sw  = stable[SW_W-1:0];
  assign stable_btn = stable[IN_W-1:SW_W];

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel_off = {addr[3:2], 2'b00};
  assign wr_evt  = wen && hit && (sel_off == OFF_EVT);
  assign wr_mask = wen && hit && (sel_off == OFF_MASK);

  assign unused_bus_bits = ^{addr[1:0], wdata[31:BTN_W]};

  always_comb begin
    btn_prev_d = stable_btn;
    btn_rise   = stable_btn & ~btn_prev_q;
    evt_clr    = wr_evt ? wdata[BTN_W-1:0] : '0;
    // A rise in the same cycle as a clear keeps the bit set.
    evt_d      = (evt_q & ~evt_clr) | btn_rise;
    mask_d     = wr_mask ? wdata[BTN_W-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      btn_prev_q <= '0;
      evt_q      <= '0;
      mask_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      evt_q      <= evt_d;
      mask_q     <= mask_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel_off)
        OFF_SW:   rdata = {8'h00, stable_sw};
        OFF_BTN:  rdata = zext_btn(stable_btn);
        OFF_EVT:  rdata = zext_btn(evt_q);
        OFF_MASK: rdata = zext_btn(mask_q);
        default:  rdata = '0;
      endcase
    end
  end

  assign irq = |(evt_q & mask_q);

endmodule
